// File: rtl/poseidon_arc_lanes.sv
`timescale 1ns/1ps
// poseidon_arc_lanes
// Add-round-constant stage for the Poseidon permutation, T lanes per state
// vector. One valid/ready transfer carries a whole state vector, its T round
// constants and the modulus. The lanes then pass one at a time through a
// single 2-stage modular add/sub pipeline. The reduced vector is returned
// together with a per-lane flag that marks lanes needing the correction step.
//
// Ports
//   i_clk, i_rstn   clock, asynchronous active-low reset
//   i_valid/o_ready input vector handshake (o_ready only while IDLE)
//   i_mode          1 = state + rc mod p, 0 = state - rc mod p
//   i_state, i_rc   T lanes of DW bits, lane k at [k*DW +: DW]
//   i_p             modulus
//   o_valid/i_ready result vector handshake
//   o_state         result lanes, same packing as i_state
//   o_flag          bit k set when lane k needed the correction step
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds valid and data steady until that edge. The
// consumer may toggle ready freely. This block never takes a new vector while
// one is in flight, and o_state/o_flag stay stable while o_valid is high.
module poseidon_arc_lanes #(
    parameter int DW = 256,
    parameter int T  = 3
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic            i_mode,
    input  logic [T*DW-1:0] i_state,
    input  logic [T*DW-1:0] i_rc,
    input  logic [DW-1:0]   i_p,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [T*DW-1:0] o_state,
    output logic [T-1:0]    o_flag
);

    localparam int IW = (T > 1) ? $clog2(T) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(T - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;

    logic [IW-1:0]   idx;
    logic [T*DW-1:0] a_q;
    logic [T*DW-1:0] b_q;
    logic [DW-1:0]   p_q;
    logic            mode_q;

    // S1 registers
    logic            s1_valid;
    logic [IW-1:0]   s1_idx;
    logic [DW:0]     s1_r;

    // Lane select and raw add/sub for S1. In sub mode bit DW is the borrow.
    logic [DW-1:0] a_lane;
    logic [DW-1:0] b_lane;
    logic [DW:0]   raw;

    always_comb begin
        a_lane = '0;
        b_lane = '0;
        for (int k = 0; k < T; k++) begin
            if (idx == IW'(k)) begin
                a_lane = a_q[k*DW +: DW];
                b_lane = b_q[k*DW +: DW];
            end
        end
        if (mode_q) begin
            raw = {1'b0, a_lane} + {1'b0, b_lane};
        end else begin
            raw = {1'b0, a_lane} - {1'b0, b_lane};
        end
    end

    // S2 correction. The low DW bits of r - p only depend on the low DW bits
    // of r, so the add-mode subtract can be done at DW width.
    logic [DW-1:0] s2_res;
    logic          s2_flag;

    always_comb begin
        s2_res  = s1_r[DW-1:0];
        s2_flag = 1'b0;
        if (mode_q) begin
            if (s1_r >= {1'b0, p_q}) begin
                s2_res  = s1_r[DW-1:0] - p_q;
                s2_flag = 1'b1;
            end
        end else if (s1_r[DW]) begin
            s2_res  = s1_r[DW-1:0] + p_q;
            s2_flag = 1'b1;
        end
    end

    // Control FSM with registered handshake outputs.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state   <= IDLE;
            idx     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            mode_q  <= 1'b0;
            o_ready <= 1'b1;
            o_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        a_q     <= i_state;
                        b_q     <= i_rc;
                        p_q     <= i_p;
                        mode_q  <= i_mode;
                        idx     <= '0;
                        o_ready <= 1'b0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    idx <= idx + IW'(1);
                    if (idx == LAST_IDX) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The last lane is written by S2 on this same edge.
                    o_valid <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Datapath: S1 capture and S2 write-back into the output lanes.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            s1_valid <= 1'b0;
            s1_idx   <= '0;
            s1_r     <= '0;
            o_state  <= '0;
            o_flag   <= '0;
        end else begin
            s1_valid <= (state == RUN);
            s1_idx   <= idx;
            s1_r     <= raw;
            if (state == IDLE && i_valid) begin
                o_flag <= '0;
            end else if (s1_valid) begin
                for (int k = 0; k < T; k++) begin
                    if (s1_idx == IW'(k)) begin
                        o_state[k*DW +: DW] <= s2_res;
                        o_flag[k]           <= s2_flag;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_poseidon_arc_lanes.sv
`timescale 1ns/1ps
module tb_poseidon_arc_lanes;

    localparam int DW = 256;
    localparam int T  = 3;
    localparam int EW = T*DW + T;
    localparam logic [DW-1:0] P_BN =
        256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
    localparam logic [DW-1:0] P_SMALL = 256'd251;

    // ---------------- clock / reset ----------------
    logic clk;
    logic i_rstn;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT (DW=256, T=3) ----------------
    logic            i_valid;
    logic            o_ready;
    logic            i_mode;
    logic [T*DW-1:0] i_state;
    logic [T*DW-1:0] i_rc;
    logic [DW-1:0]   i_p;
    logic            o_valid;
    logic            i_ready;
    logic [T*DW-1:0] o_state;
    logic [T-1:0]    o_flag;

    poseidon_arc_lanes #(.DW(DW), .T(T)) u_dut (
        .i_clk   (clk),
        .i_rstn  (i_rstn),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_mode  (i_mode),
        .i_state (i_state),
        .i_rc    (i_rc),
        .i_p     (i_p),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_state (o_state),
        .o_flag  (o_flag)
    );

    // ---------------- single-lane DUT (DW=8, T=1) ----------------
    logic       t1_valid;
    logic       t1_oready;
    logic       t1_mode;
    logic [7:0] t1_state;
    logic [7:0] t1_rc;
    logic [7:0] t1_p;
    logic       t1_ovalid;
    logic       t1_iready;
    logic [7:0] t1_ostate;
    logic [0:0] t1_oflag;

    poseidon_arc_lanes #(.DW(8), .T(1)) u_dut_t1 (
        .i_clk   (clk),
        .i_rstn  (i_rstn),
        .i_valid (t1_valid),
        .o_ready (t1_oready),
        .i_mode  (t1_mode),
        .i_state (t1_state),
        .i_rc    (t1_rc),
        .i_p     (t1_p),
        .o_valid (t1_ovalid),
        .i_ready (t1_iready),
        .o_state (t1_ostate),
        .o_flag  (t1_oflag)
    );

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    time           acc_q[$];
    time           cons_time = 0;
    int            n_chk  = 0;
    int            n_pass = 0;
    bit            rdy_rand  = 1'b0;
    bit            rdy_force = 1'b1;

    task automatic chk(input string nm, input logic [EW-1:0] got, input logic [EW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic chk_int(input string nm, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        $display("FAIL %s: no response within cycle budget", nm);
    endtask

    // ---------------- reference model ----------------
    // Per lane: (a + b) mod p or (a - b) mod p, flag when the unreduced value
    // fell outside [0, p).
    function automatic logic [EW-1:0] model_vec(input logic [T*DW-1:0] st,
                                                input logic [T*DW-1:0] rc,
                                                input logic [DW-1:0] p,
                                                input logic mode);
        logic [T*DW-1:0] res;
        logic [T-1:0]    fl;
        logic [DW+1:0]   a, b, pp, r;
        res = '0;
        fl  = '0;
        pp  = {2'b00, p};
        for (int k = 0; k < T; k++) begin
            a = {2'b00, st[k*DW +: DW]};
            b = {2'b00, rc[k*DW +: DW]};
            if (mode) begin
                r     = (a + b) % pp;
                fl[k] = (a + b >= pp);
            end else begin
                r     = (a + pp - b) % pp;
                fl[k] = (a < b);
            end
            res[k*DW +: DW] = r[DW-1:0];
        end
        return {fl, res};
    endfunction

    function automatic logic [T*DW-1:0] pack3(input int unsigned a0, input int unsigned a1,
                                             input int unsigned a2);
        return {DW'(a2), DW'(a1), DW'(a0)};
    endfunction

    function automatic logic [DW-1:0] rnd_elem(input logic [DW-1:0] p);
        logic [DW-1:0] v;
        for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return p - 1;
            default: return v % p;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_vec(input logic [T*DW-1:0] st, input logic [T*DW-1:0] rc,
                            input logic [DW-1:0] p, input logic mode, output time acc);
        int n = 0;
        @(negedge clk);
        i_state = st;
        i_rc    = rc;
        i_p     = p;
        i_mode  = mode;
        i_valid = 1'b1;
        while (!o_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!o_ready) begin
            fail_now("send_accept");
            i_valid = 1'b0;
            acc = 0;
        end else begin
            @(posedge clk);
            acc = $time;
            exp_q.push_back(model_vec(st, rc, p, mode));
            acc_q.push_back($time);
            #1 i_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) fail_now("drain");
        @(negedge clk);
    endtask

    // Downstream ready: forced level or random, updated just after each negedge.
    initial begin
        i_ready = 1'b1;
        forever begin
            @(negedge clk);
            #1;
            i_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
        end
    end

    // ---------------- compare process ----------------
    // Samples 2 time units after each negedge; a hand-off happens on the
    // following posedge when o_valid && i_ready.
    initial begin
        bit seen;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!i_rstn) begin
                seen = 1'b0;
            end else begin
                chk("o_ready", o_ready, exp_q.size() == 0);
                if (o_valid) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_o_valid");
                    end else begin
                        if (!seen) begin
                            seen = 1'b1;
                            chk_int("latency", ($time - 7 - acc_q[0]) / 10, T + 1);
                        end
                        chk("flag_state", {o_flag, o_state}, exp_q[0]);
                        if (i_ready) begin
                            void'(exp_q.pop_front());
                            void'(acc_q.pop_front());
                            seen      = 1'b0;
                            cons_time = $time + 3;
                        end
                    end
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        time t_acc;
        int  n;

        i_rstn    = 1'b0;
        i_valid   = 1'b0;
        i_mode    = 1'b0;
        i_state   = '0;
        i_rc      = '0;
        i_p       = '0;
        t1_valid  = 1'b0;
        t1_mode   = 1'b0;
        t1_state  = '0;
        t1_rc     = '0;
        t1_p      = '0;
        t1_iready = 1'b1;

        repeat (3) @(negedge clk);
        i_rstn = 1'b1;
        #3;
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_state", o_state, 0);
        chk("rst_o_flag", o_flag, 0);
        chk("rst_o_ready", o_ready, 1);
        chk("rst_t1_o_valid", t1_ovalid, 0);

        // Hand-computed values pinning the model
        chk("pin_add", model_vec(pack3(10, 200, 250), pack3(5, 100, 1), P_SMALL, 1'b1),
            {3'b110, pack3(15, 49, 0)});
        chk("pin_sub", model_vec(pack3(10, 5, 0), pack3(3, 9, 0), P_SMALL, 1'b0),
            {3'b010, pack3(7, 247, 0)});
        chk("pin_add_edge", model_vec(pack3(250, 0, 0), pack3(1, 0, 0), P_SMALL, 1'b1),
            {3'b001, pack3(0, 0, 0)});
        chk("pin_sub_edge", model_vec(pack3(0, 7, 250), pack3(250, 7, 0), P_SMALL, 1'b0),
            {3'b001, pack3(1, 0, 250)});

        // Directed vectors, downstream always ready
        rdy_force = 1'b1;
        send_vec(pack3(10, 200, 250), pack3(5, 100, 1), P_SMALL, 1'b1, t_acc);
        send_vec(pack3(10, 5, 0), pack3(3, 9, 0), P_SMALL, 1'b0, t_acc);
        send_vec(pack3(250, 0, 0), pack3(1, 0, 0), P_SMALL, 1'b1, t_acc);
        send_vec(pack3(0, 7, 250), pack3(250, 7, 0), P_SMALL, 1'b0, t_acc);
        drain();

        // Backpressure: hold result for 10 cycles while junk input is offered
        rdy_force = 1'b0;
        send_vec(pack3(1, 2, 3), pack3(250, 249, 248), P_SMALL, 1'b1, t_acc);
        n = 0;
        while (!o_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!o_valid) fail_now("bp_wait_valid");
        repeat (10) begin
            @(negedge clk);
            i_valid = 1'b1;
            i_state = pack3($urandom_range(0, 250), $urandom_range(0, 250), 7);
            i_mode  = ~i_mode;
        end
        @(negedge clk);
        i_valid   = 1'b0;
        rdy_force = 1'b1;
        send_vec(pack3(100, 0, 17), pack3(200, 0, 17), P_SMALL, 1'b0, t_acc);
        chk_int("accept_after_done", t_acc - cons_time, 10);
        drain();

        // Reset in the middle of RUN (lane index 1)
        send_vec(pack3(5, 6, 7), pack3(1, 1, 1), P_SMALL, 1'b1, t_acc);
        @(posedge clk);
        @(negedge clk);
        i_rstn = 1'b0;
        exp_q.delete();
        acc_q.delete();
        repeat (2) @(negedge clk);
        i_rstn = 1'b1;
        #3;
        chk("mid_rst_o_valid", o_valid, 0);
        chk("mid_rst_o_state", o_state, 0);
        chk("mid_rst_o_flag", o_flag, 0);
        chk("mid_rst_o_ready", o_ready, 1);
        send_vec(pack3(240, 3, 250), pack3(20, 4, 250), P_SMALL, 1'b1, t_acc);
        drain();

        // Single-lane build: add 250 + 1 -> 0 (flag), then sub 0 - 250 -> 1 (flag)
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            t1_p     = 8'd251;
            t1_mode  = (j == 0);
            t1_state = (j == 0) ? 8'd250 : 8'd0;
            t1_rc    = (j == 0) ? 8'd1 : 8'd250;
            t1_valid = 1'b1;
            chk("t1_o_ready", t1_oready, 1);
            @(posedge clk);
            #1 t1_valid = 1'b0;
            n = 0;
            while (!t1_ovalid && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk_int("t1_latency", n, 2);
            chk("t1_o_state", t1_ostate, (j == 0) ? 8'd0 : 8'd1);
            chk("t1_o_flag", t1_oflag, 1);
            @(negedge clk);
        end

        // Random back-to-back vectors over the BN254 scalar field
        rdy_rand = 1'b1;
        for (int v = 0; v < 1000; v++) begin
            logic [T*DW-1:0] st;
            logic [T*DW-1:0] rc;
            for (int k = 0; k < T; k++) begin
                st[k*DW +: DW] = rnd_elem(P_BN);
                rc[k*DW +: DW] = rnd_elem(P_BN);
            end
            repeat ($urandom_range(0, 1)) @(negedge clk);
            send_vec(st, rc, P_BN, 1'($urandom_range(0, 1)), t_acc);
        end
        rdy_rand  = 1'b0;
        rdy_force = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
